// File: rtl/edge_trigger_detector_if.sv
// edge_trigger_detector_if: channel inputs, trigger controls and trigger outputs.
// Revision 1.0
`default_nettype none

interface edge_trigger_detector_if #(
  parameter int CHANNELS      = 4,
  parameter int HOLDOFF_WIDTH = 16,
  parameter int COUNT_WIDTH   = 16
);
  logic [CHANNELS-1:0]      state_in;
  logic                     enable;
  logic [1:0]               mode;
  logic [HOLDOFF_WIDTH-1:0] holdoff;
  logic                     clear_count;
  logic [CHANNELS-1:0]      trigger;
  logic [CHANNELS-1:0]      level;
  logic                     any_trigger;
  logic [COUNT_WIDTH-1:0]   edge_count;

  modport master (
    output state_in, enable, mode, holdoff, clear_count,
    input  trigger, level, any_trigger, edge_count
  );

  modport slave (
    input  state_in, enable, mode, holdoff, clear_count,
    output trigger, level, any_trigger, edge_count
  );
endinterface

`default_nettype wire

// File: rtl/edge_trigger_detector.sv
// edge_trigger_detector: per-channel sync, glitch filter, edge select, holdoff, event counter.
// Revision 1.0
`default_nettype none

module edge_trigger_detector #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_LEN    = 4,
  parameter int HOLDOFF_WIDTH = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  edge_trigger_detector_if.slave  bus
);

  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

  logic [CHANNELS-1:0]      sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]      level_q;
  logic [CHANNELS-1:0]      trigger_q;
  logic [FCNT_W-1:0]        fcnt_q [CHANNELS];
  logic [HOLDOFF_WIDTH-1:0] hcnt_q [CHANNELS];
  logic [COUNT_WIDTH-1:0]   count_q;

  logic [CHANNELS-1:0] synced;
  logic [CHANNELS-1:0] flip;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] trig_d;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= bus.state_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // A level flip is the only place an edge can be qualified.
  always_comb begin
    flip   = '0;
    accept = '0;
    trig_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      flip[i]   = (synced[i] != level_q[i]) && (fcnt_q[i] == FCNT_LAST);
      accept[i] = flip[i] && (synced[i] ? bus.mode[0] : bus.mode[1]);
      trig_d[i] = accept[i] && bus.enable && (hcnt_q[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q   <= '0;
      trigger_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        fcnt_q[i] <= '0;
        hcnt_q[i] <= '0;
      end
    end else begin
      trigger_q <= trig_d;
      for (int i = 0; i < CHANNELS; i++) begin
        if (synced[i] == level_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (flip[i]) begin
          level_q[i] <= synced[i];
          fcnt_q[i]  <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FCNT_W'(1);
        end

        // Disabling clears holdoff so a re-enable starts unsuppressed.
        if (!bus.enable) begin
          hcnt_q[i] <= '0;
        end else if (trig_d[i]) begin
          hcnt_q[i] <= bus.holdoff;
        end else if (hcnt_q[i] != '0) begin
          hcnt_q[i] <= hcnt_q[i] - HOLDOFF_WIDTH'(1);
        end
      end

      if (bus.clear_count) begin
        count_q <= '0;
      end else if ((|trig_d) && (count_q != '1)) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign bus.trigger     = trigger_q;
  assign bus.level       = level_q;
  assign bus.any_trigger = |trigger_q;
  assign bus.edge_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_trigger_detector.sv
// tb_edge_trigger_detector: directed stimulus, window-based reference model, per-cycle compare.
// Revision 1.0
`default_nettype none

module tb_edge_trigger_detector;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int WIN  = SYNC + FILT;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  edge_trigger_detector_if #(.CHANNELS(CH), .HOLDOFF_WIDTH(16), .COUNT_WIDTH(16)) bus ();
  edge_trigger_detector_if #(.CHANNELS(CH), .HOLDOFF_WIDTH(16), .COUNT_WIDTH(4))  bus4 ();

  assign bus4.state_in    = bus.state_in;
  assign bus4.enable      = bus.enable;
  assign bus4.mode        = bus.mode;
  assign bus4.holdoff     = bus.holdoff;
  assign bus4.clear_count = bus.clear_count;

  edge_trigger_detector #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .HOLDOFF_WIDTH(16), .COUNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  edge_trigger_detector #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .HOLDOFF_WIDTH(16), .COUNT_WIDTH(4)
  ) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: level flips once the last FILT synchronised samples all
  // disagree with it; holdoff is tracked as the first cycle a channel may fire.
  logic [WIN-1:0] hist [CH];
  logic [WIN-1:0] nh   [CH];
  logic [CH-1:0]  m_level, m_trig, nxt_level, nxt_trig;
  longint         cyc;
  longint         blocked [CH];
  int             m_count, m_count4;

  always_comb begin
    nxt_level = m_level;
    nxt_trig  = '0;
    nh        = '{default: '0};
    for (int i = 0; i < CH; i++) begin
      nh[i] = {hist[i][WIN-2:0], bus.state_in[i]};
      if (nh[i][WIN-1:SYNC] == {FILT{~m_level[i]}}) begin
        nxt_level[i] = ~m_level[i];
        nxt_trig[i]  = (nxt_level[i] ? bus.mode[0] : bus.mode[1]) && bus.enable
                       && (cyc >= blocked[i]);
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc      <= 0;
      m_level  <= '0;
      m_trig   <= '0;
      m_count  <= 0;
      m_count4 <= 0;
      for (int i = 0; i < CH; i++) begin
        hist[i]    <= '0;
        blocked[i] <= 0;
      end
    end else begin
      cyc     <= cyc + 1;
      m_level <= nxt_level;
      m_trig  <= nxt_trig;
      for (int i = 0; i < CH; i++) begin
        hist[i] <= nh[i];
        if (!bus.enable)      blocked[i] <= 0;
        else if (nxt_trig[i]) blocked[i] <= cyc + longint'(bus.holdoff) + 1;
      end
      if (bus.clear_count) begin
        m_count  <= 0;
        m_count4 <= 0;
      end else if (|nxt_trig) begin
        if (m_count < 65535) m_count <= m_count + 1;
        if (m_count4 < 15)   m_count4 <= m_count4 + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("trigger",      32'(bus.trigger),     32'(m_trig));
    check("level",        32'(bus.level),       32'(m_level));
    check("any_trigger",  32'(bus.any_trigger), 32'(|m_trig));
    check("edge_count",   32'(bus.edge_count),  32'(m_count));
    check("edge_count4",  32'(bus4.edge_count), 32'(m_count4));
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst             = 1'b0;
    bus.state_in    = '0;
    bus.enable      = 1'b0;
    bus.mode        = 2'b00;
    bus.holdoff     = '0;
    bus.clear_count = 1'b0;
    wait_n(2);
    check("rst_trigger", 32'(bus.trigger), 32'h0);
    check("rst_count",   32'(bus.edge_count), 32'h0);

    // Basic rising latency on ch0
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.mode   = 2'b01;
    bus.state_in[0] = 1'b1;
    wait_n(5);
    check("lat_early_trig", 32'(bus.trigger), 32'h0);
    check("lat_early_lvl",  32'(bus.level),   32'h0);
    wait_n(1);
    check("lat_trig",  32'(bus.trigger),    32'h1);
    check("lat_lvl",   32'(bus.level),      32'h1);
    check("lat_count", 32'(bus.edge_count), 32'd1);
    wait_n(1);
    check("lat_pulse", 32'(bus.trigger), 32'h0);

    // Glitch of 3 samples is rejected; 4 samples passes in both directions
    bus.state_in[1] = 1'b1;
    wait_n(3);
    bus.state_in[1] = 1'b0;
    wait_n(10);
    check("glitch_lvl",   32'(bus.level),      32'h1);
    check("glitch_count", 32'(bus.edge_count), 32'd1);
    bus.mode = 2'b11;
    bus.state_in[1] = 1'b1;
    wait_n(4);
    bus.state_in[1] = 1'b0;
    wait_n(20);
    check("pulse4_count", 32'(bus.edge_count), 32'd3);

    // Falling-only, then off
    bus.mode = 2'b10;
    bus.state_in[2] = 1'b1;
    wait_n(10);
    bus.state_in[2] = 1'b0;
    wait_n(20);
    check("fall_count", 32'(bus.edge_count), 32'd4);
    bus.mode = 2'b00;
    bus.state_in[2] = 1'b1;
    wait_n(10);
    bus.state_in[2] = 1'b0;
    wait_n(20);
    check("off_count", 32'(bus.edge_count), 32'd4);

    // Holdoff 20 with ch0 changing every 8 cycles
    bus.mode    = 2'b11;
    bus.holdoff = 16'd20;
    for (int k = 0; k < 4; k++) begin
      bus.state_in[0] = ~bus.state_in[0];
      wait_n(8);
    end
    wait_n(30);
    check("holdoff_count", 32'(bus.edge_count), 32'd6);

    // Simultaneous ch0/ch3, then again with clear_count on the trigger cycle
    bus.holdoff = '0;
    bus.state_in[0] = 1'b0;
    bus.state_in[3] = 1'b1;
    wait_n(6);
    check("simul_trig",  32'(bus.trigger),     32'h9);
    check("simul_any",   32'(bus.any_trigger), 32'h1);
    check("simul_count", 32'(bus.edge_count),  32'd7);
    wait_n(10);
    bus.state_in[0] = 1'b1;
    bus.state_in[3] = 1'b0;
    wait_n(5);
    bus.clear_count = 1'b1;
    wait_n(1);
    bus.clear_count = 1'b0;
    check("clr_trig",  32'(bus.trigger),    32'h9);
    check("clr_count", 32'(bus.edge_count), 32'd0);

    // Edges while disabled never fire, and re-enabling is quiet
    wait_n(10);
    bus.enable = 1'b0;
    bus.state_in[3] = 1'b1;
    wait_n(12);
    check("dis_lvl", 32'(bus.level), 32'h9);
    bus.enable = 1'b1;
    wait_n(12);
    check("dis_count", 32'(bus.edge_count), 32'd0);

    // 20 triggers on ch1: 16-bit counter reaches 20, 4-bit saturates at 15
    for (int k = 0; k < 20; k++) begin
      bus.state_in[1] = ~bus.state_in[1];
      wait_n(5);
    end
    wait_n(10);
    check("sat_count16", 32'(bus.edge_count),  32'd20);
    check("sat_count4",  32'(bus4.edge_count), 32'd15);

    // Asynchronous reset in the middle of a holdoff window
    bus.holdoff = 16'd50;
    bus.state_in[2] = 1'b1;
    wait_n(10);
    #2 rst = 1'b0;
    bus.state_in = 4'b0100;
    #1;
    check("arst_trig",  32'(bus.trigger),     32'h0);
    check("arst_lvl",   32'(bus.level),       32'h0);
    check("arst_any",   32'(bus.any_trigger), 32'h0);
    check("arst_count", 32'(bus.edge_count),  32'h0);
    wait_n(2);
    rst = 1'b1;
    wait_n(5);
    check("rel_early", 32'(bus.trigger), 32'h0);
    wait_n(1);
    check("rel_trig",  32'(bus.trigger),    32'h4);
    check("rel_count", 32'(bus.edge_count), 32'd1);
    wait_n(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/edge_trigger_detector.md
Name: edge_trigger_detector

Overview:
Multi-channel edge trigger generator for the acquisition path. It replaces single-bit rising-edge detection with per-channel synchronisation, glitch filtering, selectable edge polarity and per-channel retrigger holdoff. It emits one-cycle trigger pulses and keeps a saturating trigger-event counter. It sits between comparator/threshold outputs and the capture/decimation control logic.

Parameters:
CHANNELS, 4, number of independent input channels
SYNC_STAGES, 2, synchroniser flops per channel (legal >= 2)
FILTER_LEN, 4, consecutive differing samples required to accept a new level (legal >= 1; 1 = no filtering)
HOLDOFF_WIDTH, 16, width of holdoff input and per-channel holdoff counters
COUNT_WIDTH, 16, width of event counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
state_in  in  CHANNELS  raw asynchronous channel inputs
enable  in  1  trigger generation enable
mode  in  2  00 off, 01 rising, 10 falling, 11 both edges (global to all channels)
holdoff  in  HOLDOFF_WIDTH  cycles of edge suppression after each trigger on a channel
clear_count  in  1  synchronous clear of edge_count
trigger  out  CHANNELS  registered one-cycle trigger pulse per channel
level  out  CHANNELS  filtered, synchronised channel level
any_trigger  out  1  OR of trigger bits, derived from registers only
edge_count  out  COUNT_WIDTH  saturating count of cycles with any trigger

Behaviour:
- Reset (rst low, async): sync chains, level, filter counters, holdoff counters, trigger and edge_count all go to 0. any_trigger is therefore 0.
- Sync: state_in[i] passes through SYNC_STAGES flops. s[i] is the last stage.
- Filter, per channel, counter fcnt 0..FILTER_LEN-1:
  - s == level: fcnt <= 0.
  - s != level and fcnt < FILTER_LEN-1: fcnt++.
  - s != level and fcnt == FILTER_LEN-1: level <= s, fcnt <= 0.
  - A pulse shorter than FILTER_LEN samples never changes level.
- Edge qualify, in the cycle level updates: rising = 0->1, falling = 1->0. The edge is accepted per mode. mode 00 accepts nothing.
- Latency: state_in changes before edge k and stays stable. level and trigger both become high after edge k+SYNC_STAGES+FILTER_LEN-1. With default parameters that is edge k+5.
- trigger[i] <= accepted edge AND enable AND (hcnt[i] == 0). It is high for exactly one cycle per accepted edge.
- Holdoff, per channel:
  - When trigger[i] is loaded 1, hcnt[i] <= holdoff, sampled in that cycle.
  - Otherwise hcnt[i] decrements while nonzero.
  - Edges arriving while hcnt != 0 are dropped, not deferred. level still tracks during holdoff.
  - holdoff = 0 means no suppression: triggers are possible on consecutive level changes.
- enable low: trigger forced 0 and all hcnt cleared. Sync, filter and level keep running, so re-enabling produces no spurious edge from stale level.
- mode and enable changes take effect for edges qualified on the next clock edge.
- edge_count:
  - Increments by 1 on the clock edge where trigger is loaded nonzero. Multiple simultaneous channels count once.
  - Saturates at all-ones; no wrap.
  - clear_count has priority: zeroes the counter, and a trigger in the same cycle is not counted.
- Channels are fully independent apart from the shared mode, enable, holdoff and edge_count.
- Reset released with an input held high: level starts at 0, so one rising trigger appears after the normal latency. This is the required behaviour.

Test Plan:
- Defaults, mode=01, holdoff=0: state_in[0] 0->1 before edge 0 -> level[0] and trigger[0] high after edge 5 only, one cycle; edge_count=1.
- Glitch rejection: state_in[1] high for 3 cycles, FILTER_LEN=4 -> no level or trigger change. A 4-cycle pulse -> one rising trigger, and one falling trigger if mode=11.
- mode=10, ch2 toggles 0->1->0, each level held 10 cycles -> single trigger on the falling level update only. With mode=00 -> no trigger and edge_count unchanged.
- holdoff=20, ch0 level changes every 8 cycles, mode=11 -> triggers at the first change, then the change 24 cycles later; changes at +8 and +16 are dropped.
- Simultaneous ch0/ch3 edges -> trigger=4'b1001 for one cycle and edge_count +1. clear_count in the same cycle -> edge_count=0.
- COUNT_WIDTH=4, 20 triggers -> edge_count stops at 15. Assert rst mid-holdoff -> all outputs 0 immediately; after release, an input held high -> one rising trigger after 5 cycles.
